// File: rtl/serial_add_arbiter.sv
// rtl/serial_add_arbiter.sv - round-robin arbiter sharing one bit-serial adder between two requesters
module serial_add_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clkout,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             cin0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic             cin1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic             done,
  output logic             owner,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] areg, breg, sreg;
  logic             c;
  logic [CW-1:0]    cnt;
  logic             last;
  logic             win;
  logic             s_bit, c_nxt;

  // Ties go to the requester that was not served last.
  assign win   = (req0 && req1) ? ~last : req1;
  assign s_bit = areg[0] ^ breg[0] ^ c;
  assign c_nxt = (areg[0] & breg[0]) | (areg[0] & c) | (breg[0] & c);
  assign busy  = (state != IDLE);

  always_ff @(posedge clkout or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req0 || req1) state_nxt = SHIFT;
      SHIFT:   if (cnt == LAST_BIT) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clkout or negedge rst) begin
    if (!rst) begin
      areg  <= '0;
      breg  <= '0;
      sreg  <= '0;
      c     <= 1'b0;
      cnt   <= '0;
      last  <= 1'b1;
      owner <= 1'b0;
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            last  <= win;
            owner <= win;
            gnt0  <= ~win;
            gnt1  <= win;
            areg  <= win ? a1 : a0;
            breg  <= win ? b1 : b0;
            c     <= win ? cin1 : cin0;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          areg <= areg >> 1;
          breg <= breg >> 1;
          c    <= c_nxt;
          sreg <= {s_bit, sreg[WIDTH-1:1]};
          cnt  <= cnt + 1'b1;
          if (cnt == LAST_BIT) begin
            sum  <= {s_bit, sreg[WIDTH-1:1]};
            cout <= c_nxt;
            done <= 1'b1;
          end
        end
        DONE: begin
          done <= 1'b0;
          gnt0 <= 1'b0;
          gnt1 <= 1'b0;
        end
        default: begin
          done <= 1'b0;
          gnt0 <= 1'b0;
          gnt1 <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_arbiter.sv
// tb/tb_serial_add_arbiter.sv - self-checking bench for serial_add_arbiter
module tb_serial_add_arbiter;

  localparam int W = 4;

  logic         clkout, rst;
  logic         req0, req1, cin0, cin1;
  logic [W-1:0] a0, b0, a1, b1;
  logic         gnt0, gnt1, busy, done, owner, cout;
  logic [W-1:0] sum;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic         r0, r1;
    logic [W-1:0] a0, b0;
    logic         c0;
    logic [W-1:0] a1, b1;
    logic         c1;
    logic         owner;
    logic [W-1:0] sum;
    logic         cout;
  } vec_t;

  serial_add_arbiter #(.WIDTH(W)) dut (
    .clkout(clkout), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0), .cin0(cin0),
    .req1(req1), .a1(a1), .b1(b1), .cin1(cin1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done),
    .owner(owner), .sum(sum), .cout(cout)
  );

  initial clkout = 1'b0;
  always #5 clkout = ~clkout;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r0, input logic r1,
                              input logic [W-1:0] xa0, input logic [W-1:0] xb0, input logic c0,
                              input logic [W-1:0] xa1, input logic [W-1:0] xb1, input logic c1,
                              input logic o, input logic [W-1:0] s, input logic co);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.a0 = xa0; v.b0 = xb0; v.c0 = c0;
    v.a1 = xa1; v.b1 = xb1; v.c1 = c1; v.owner = o; v.sum = s; v.cout = co;
    return v;
  endfunction

  // Reference: fair arbitration plus plain integer addition.
  function automatic vec_t model(input vec_t vin, input logic lst);
    vec_t v;
    logic [W:0] full;
    v = vin;
    v.owner = (v.r0 && v.r1) ? !lst : v.r1;
    if (v.owner) full = {1'b0, v.a1} + {1'b0, v.b1} + {{W{1'b0}}, v.c1};
    else         full = {1'b0, v.a0} + {1'b0, v.b0} + {{W{1'b0}}, v.c0};
    v.sum  = full[W-1:0];
    v.cout = full[W];
    return v;
  endfunction

  task automatic run_op(input vec_t v);
    int lat;
    @(negedge clkout);
    req0 = v.r0; req1 = v.r1;
    a0 = v.a0; b0 = v.b0; cin0 = v.c0;
    a1 = v.a1; b1 = v.b1; cin1 = v.c1;
    @(negedge clkout);
    chk("gnt0_at_grant", 32'(gnt0), 32'(!v.owner));
    chk("gnt1_at_grant", 32'(gnt1), 32'(v.owner));
    chk("busy_at_grant", 32'(busy), 1);
    req0 = 1'b0; req1 = 1'b0;
    lat = 1;
    while (!done && lat < 10) begin
      @(negedge clkout);
      lat++;
      if (lat == 2) begin
        a0 = 4'($urandom); b0 = 4'($urandom); cin0 = 1'($urandom);
        a1 = 4'($urandom); b1 = 4'($urandom); cin1 = 1'($urandom);
      end
    end
    chk("done_latency", lat, 5);
    chk("sum", 32'(sum), 32'(v.sum));
    chk("cout", 32'(cout), 32'(v.cout));
    chk("owner", 32'(owner), 32'(v.owner));
    chk("gnt_hold", 32'({gnt1, gnt0}), v.owner ? 2 : 1);
    @(negedge clkout);
    chk("done_pulse_end", 32'(done), 0);
    chk("gnt_release", 32'({gnt1, gnt0}), 0);
    chk("busy_release", 32'(busy), 0);
    chk("sum_hold", 32'(sum), 32'(v.sum));
  endtask

  initial begin
    vec_t tbl[7];
    vec_t v;
    logic mlast;
    int   seen;
    logic [1:0] r;

    tbl[0] = mk(1'b1, 1'b0, 4'd3,  4'd5,  1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd8,  1'b0);
    tbl[1] = mk(1'b0, 1'b1, 4'd0,  4'd0,  1'b0, 4'd15, 4'd1, 1'b1, 1'b1, 4'd1,  1'b1);
    tbl[2] = mk(1'b1, 1'b1, 4'd2,  4'd2,  1'b0, 4'd7, 4'd9, 1'b0, 1'b0, 4'd4,  1'b0);
    tbl[3] = mk(1'b1, 1'b1, 4'd2,  4'd2,  1'b0, 4'd7, 4'd9, 1'b0, 1'b1, 4'd0,  1'b1);
    tbl[4] = mk(1'b1, 1'b1, 4'd9,  4'd9,  1'b1, 4'd1, 4'd1, 1'b0, 1'b0, 4'd3,  1'b1);
    tbl[5] = mk(1'b1, 1'b0, 4'd15, 4'd15, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd15, 1'b1);
    tbl[6] = mk(1'b1, 1'b1, 4'd0,  4'd0,  1'b0, 4'd8, 4'd4, 1'b1, 1'b1, 4'd13, 1'b0);

    rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; cin0 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    repeat (2) @(negedge clkout);
    chk("reset_outputs", 32'({gnt0, gnt1, busy, done, owner, cout}), 0);
    chk("reset_sum", 32'(sum), 0);
    rst = 1'b1;

    for (int i = 0; i < 7; i++) run_op(tbl[i]);
    mlast = 1'b1;

    // Operand and request changes mid-op must not disturb the captured operation.
    run_op(mk(1'b1, 1'b0, 4'd6, 4'd5, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd12, 1'b0));
    mlast = 1'b0;

    for (int n = 0; n < 40; n++) begin
      r = 2'($urandom_range(1, 3));
      v = mk(r[0], r[1], 4'($urandom), 4'($urandom), 1'($urandom),
             4'($urandom), 4'($urandom), 1'($urandom), 1'b0, 4'd0, 1'b0);
      v = model(v, mlast);
      run_op(v);
      mlast = v.owner;
    end

    // Reset between E2 and E3 aborts without a done pulse.
    @(negedge clkout);
    req0 = 1'b1; a0 = 4'd7; b0 = 4'd7; cin0 = 1'b1;
    @(negedge clkout);
    req0 = 1'b0;
    repeat (2) @(negedge clkout);
    rst = 1'b0;
    #1;
    chk("midreset_outputs", 32'({gnt0, gnt1, busy, done, owner, cout}), 0);
    chk("midreset_sum", 32'(sum), 0);
    repeat (2) @(negedge clkout);
    rst = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clkout);
      if (done) seen++;
    end
    chk("no_done_after_abort", seen, 0);

    // Both held after reset: alternate starting with requester 0.
    @(negedge clkout);
    req0 = 1'b1; req1 = 1'b1;
    a0 = 4'd2; b0 = 4'd2; cin0 = 1'b0; a1 = 4'd7; b1 = 4'd9; cin1 = 1'b0;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clkout);
      chk("tie_done", 32'(done), (i % 6 == 5) ? 1 : 0);
      chk("tie_gnt_excl", 32'(gnt0 & gnt1), 0);
      if (i % 6 == 5) begin
        chk("tie_owner", 32'(owner), (i / 6) % 2);
        chk("tie_sum", 32'(sum), ((i / 6) % 2 == 1) ? 0 : 4);
        chk("tie_cout", 32'(cout), (i / 6) % 2);
      end
    end
    req0 = 1'b0; req1 = 1'b0;

    // Single requester held: grants every WIDTH+2 cycles with one idle cycle.
    repeat (3) @(negedge clkout);
    req0 = 1'b1; a0 = 4'd3; b0 = 4'd5; cin0 = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      @(negedge clkout);
      chk("b2b_gnt0", 32'(gnt0), (i % 6 != 0) ? 1 : 0);
      chk("b2b_done", 32'(done), (i % 6 == 5) ? 1 : 0);
      if (i % 6 == 5) chk("b2b_sum", 32'(sum), 8);
    end
    req0 = 1'b0;
    repeat (8) @(negedge clkout);
    chk("final_idle", 32'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
